// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port SRAM.
// Each access is one arbitration cycle followed by one strobe cycle.
module sram_rr_arbiter #(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [WIDTH-1:0]  p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WIDTH-1:0]  p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WIDTH-1:0]  p1_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WIDTH-1:0]  sram_wdata,
  input  logic [WIDTH-1:0]  sram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t      state;
  logic        owner;
  logic        ptr;
  logic        win;
  logic        win_wr;
  logic [1:0]  rvalid;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      p0_req && p1_req:  win = ptr;
      p1_req && !p0_req: win = 1'b1;
      default:           win = 1'b0;
    endcase
  end

  assign win_wr = win ? p1_wr : p0_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      rvalid     <= 2'b00;
      sram_addr  <= '0;
      sram_wdata <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      rvalid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            owner      <= win;
            ptr        <= ~win;
            sram_addr  <= win ? p1_addr : p0_addr;
            sram_wdata <= win ? p1_wdata : p0_wdata;
            state      <= win_wr ? WRITE : READ;
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          state         <= IDLE;
          rvalid[owner] <= 1'b1;
          if (owner) p1_rdata <= sram_rdata;
          else       p0_rdata <= sram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and grants decode from registered state only.
  assign sram_cs   = (state == WRITE) || (state == READ);
  assign sram_we   = (state == WRITE);
  assign sram_oe   = (state == READ);
  assign p0_gnt    = sram_cs && !owner;
  assign p1_gnt    = sram_cs && owner;
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];

endmodule
